// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch/button debouncer.
package debounce_pkg;

  localparam int unsigned DEFAULT_CNT_BITS = 20;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: two-flop synchronizer, four-state debounce FSM with a
// stability counter, and registered level/tick/toggle outputs.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEFAULT_CNT_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic toggle
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic [1:0]          sync_q;
  logic                s;
  db_state_t           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                db_d, rise_d, fall_d, toggle_d;

  assign s = sync_q[1];

  // Synchronizer for the asynchronous raw level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ZERO;
      cnt_q     <= CNT_ZERO;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      toggle    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_level  <= db_d;
      rise_tick <= rise_d;
      fall_tick <= fall_d;
      toggle    <= toggle_d;
    end
  end

  // Next-state and next-output logic; an aborted wait leaves outputs alone
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_d     = db_level;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle;

    case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d  = ONE;
          db_d     = 1'b1;
          rise_d   = 1'b1;
          toggle_d = ~toggle;
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ZERO;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

endmodule

// File: rtl/input_debouncer.sv
// W independent debounce channels; the top only splits and regroups the buses.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned W        = 2,
  parameter int unsigned CNT_BITS = DEFAULT_CNT_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_in,
  output logic [W-1:0] db_level,
  output logic [W-1:0] rise_tick,
  output logic [W-1:0] fall_tick,
  output logic [W-1:0] toggle
);

  for (genvar i = 0; i < W; i++) begin : g_ch
    debounce_channel #(
      .CNT_BITS (CNT_BITS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_in[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .toggle    (toggle[i])
    );
  end

endmodule
